// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared phase states and lamp encodings for the traffic sequencer
package tl_pkg;

   typedef enum logic [2:0] {
      MAIN_GRN = 3'd0,
      MAIN_EXT = 3'd1,
      MAIN_YEL = 3'd2,
      WALK     = 3'd3,
      SIDE_GRN = 3'd4,
      SIDE_EXT = 3'd5,
      SIDE_YEL = 3'd6
   } state_e;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

endpackage

// File: rtl/traffic_phase_controller_if.sv
// rtl/traffic_phase_controller_if.sv - timing, request and lamp signals of the sequencer
interface traffic_phase_controller_if;

   logic       tick;
   logic       sensor;
   logic       wr;
   logic       wr_reset;
   logic [2:0] main_light;
   logic [2:0] side_light;
   logic       walk_lamp;

   modport master (
      input  tick, sensor, wr,
      output wr_reset, main_light, side_light, walk_lamp
   );

   modport slave (
      output tick, sensor, wr,
      input  wr_reset, main_light, side_light, walk_lamp
   );

endinterface

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - tick-driven phase down-counter, expire on the tick that finds zero
module phase_timer #(
   parameter int            CW      = 4,
   parameter logic [CW-1:0] RST_VAL = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          tick,
   output logic          expire
);

   logic [CW-1:0] cnt;

   assign expire = (cnt == '0) && tick;

   // load wins over decrement so the new phase starts with its full count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= RST_VAL;
      end else if (load) begin
         cnt <= load_val;
      end else if (tick && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/traffic_phase_controller.sv
// rtl/traffic_phase_controller.sv - main/side street light sequencer with walk phase
module traffic_phase_controller
   import tl_pkg::*;
#(
   parameter int T_MAIN = 6,
   parameter int T_SIDE = 3,
   parameter int T_EXT  = 3,
   parameter int T_YEL  = 2,
   parameter int T_WALK = 3,
   parameter int CW     = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   traffic_phase_controller_if.master    bus
);

   state_e        state;
   state_e        nxt;
   logic          load;
   logic          expire;
   logic [CW-1:0] load_val;

   function automatic logic [CW-1:0] dur_m1(input state_e s);
      case (s)
         MAIN_EXT, SIDE_EXT: return CW'(T_EXT - 1);
         MAIN_YEL, SIDE_YEL: return CW'(T_YEL - 1);
         WALK:               return CW'(T_WALK - 1);
         SIDE_GRN:           return CW'(T_SIDE - 1);
         default:            return CW'(T_MAIN - 1);
      endcase
   endfunction

   function automatic logic [2:0] main_dec(input state_e s);
      case (s)
         MAIN_GRN, MAIN_EXT: return GRN;
         MAIN_YEL:           return YEL;
         default:            return RED;
      endcase
   endfunction

   function automatic logic [2:0] side_dec(input state_e s);
      case (s)
         SIDE_GRN, SIDE_EXT: return GRN;
         SIDE_YEL:           return YEL;
         default:            return RED;
      endcase
   endfunction

   // every transition happens on the expiring tick, so that is also the timer reload
   always_comb begin
      nxt  = state;
      load = expire;
      case (state)
         MAIN_GRN: if (expire) nxt = bus.sensor ? MAIN_EXT : MAIN_YEL;
         MAIN_EXT: if (expire) nxt = MAIN_YEL;
         MAIN_YEL: if (expire) nxt = bus.wr ? WALK : SIDE_GRN;
         WALK:     if (expire) nxt = SIDE_GRN;
         SIDE_GRN: if (expire) nxt = bus.sensor ? SIDE_EXT : SIDE_YEL;
         SIDE_EXT: if (expire) nxt = SIDE_YEL;
         SIDE_YEL: if (expire) nxt = MAIN_GRN;
         default: begin
            nxt  = MAIN_GRN;
            load = 1'b1;
         end
      endcase
      load_val = dur_m1(nxt);
   end

   phase_timer #(
      .CW      (CW),
      .RST_VAL (CW'(T_MAIN - 1))
   ) u_phase_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .tick     (bus.tick),
      .expire   (expire)
   );

   // lamps are registered from the next state, so they track the state register exactly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= MAIN_GRN;
         bus.main_light <= GRN;
         bus.side_light <= RED;
         bus.walk_lamp  <= 1'b0;
         bus.wr_reset   <= 1'b0;
      end else begin
         state          <= nxt;
         bus.main_light <= main_dec(nxt);
         bus.side_light <= side_dec(nxt);
         bus.walk_lamp  <= (nxt == WALK);
         bus.wr_reset   <= (nxt == WALK) && (state != WALK);
      end
   end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
Main/side-street traffic-light sequencer. Consumes the latched pedestrian request `wr` from walk_register and returns the one-cycle `wr_reset` pulse that clears it. Phase durations are counted in pulses of an external 1 Hz enable, `tick`. Light and walk-lamp outputs drive the lamp drivers directly.

Parameters:
T_MAIN, 6, main-street green duration in ticks (must be ≥1)
T_SIDE, 3, side-street green duration in ticks (≥1)
T_EXT, 3, green extension when the sensor is active, in ticks (≥1)
T_YEL, 2, yellow duration in ticks (≥1)
T_WALK, 3, pedestrian walk duration in ticks (≥1)
CW, 4, phase-timer counter width; must hold max(T_*)-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-clk-wide timing enable, nominally 1 Hz
sensor  in  1  side-street vehicle sensor, synchronous, level
wr  in  1  latched walk request from walk_register
wr_reset  out  1  one-cycle clear pulse to walk_register
main_light  out  3  {R,Y,G}, one-hot
side_light  out  3  {R,Y,G}, one-hot
walk_lamp  out  1  pedestrian walk indicator

Behaviour:
- States: MAIN_GRN, MAIN_EXT, MAIN_YEL, WALK, SIDE_GRN, SIDE_EXT, SIDE_YEL.
- Phase timer:
  - On entry to a state, the timer loads N-1, where N is that state's duration.
  - On each `tick`: if cnt==0, leave the state at that clk edge; otherwise decrement.
  - Each state therefore spans exactly N tick pulses. With no `tick`, the state holds indefinitely.
- Transitions, evaluated only at the expiring tick:
  - MAIN_GRN → MAIN_EXT if sensor=1, else MAIN_YEL.
  - MAIN_EXT → MAIN_YEL.
  - MAIN_YEL → WALK if wr=1, else SIDE_GRN.
  - WALK → SIDE_GRN.
  - SIDE_GRN → SIDE_EXT if sensor=1, else SIDE_YEL.
  - SIDE_EXT → SIDE_YEL.
  - SIDE_YEL → MAIN_GRN.
- Outputs are Moore, decoded from the state register; no added latency.
  - main_light: G in MAIN_GRN/MAIN_EXT, Y in MAIN_YEL, R otherwise.
  - side_light: G in SIDE_GRN/SIDE_EXT, Y in SIDE_YEL, R otherwise.
  - walk_lamp=1 only in WALK; both roads are red in WALK.
- wr_reset:
  - Registered; high for exactly one clk, the first clk cycle in WALK.
  - Never asserted in any other state.
- Request sampling:
  - `wr` is sampled only at the MAIN_YEL expiry edge. A request latched in that same cycle is served.
  - A request arriving during WALK, after the clear pulse, stays latched in walk_register and is served next cycle round.
- Sensor is sampled only at green expiry; at most one extension per green phase.
- Reset (rst_n=0, asynchronous): state=MAIN_GRN, cnt=T_MAIN-1, main_light=G (001), side_light=R (100), walk_lamp=0, wr_reset=0.
  - Applies immediately, including mid-WALK or mid-extension.
  - Release is sampled on clk.
- Illegal state encodings recover to MAIN_GRN on the next clk.
- `tick` held high continuously is legal: one decrement per clk.

Decomposition:
- Shared package tl_pkg:
  - state enum/localparams.
  - Light encodings RED=3'b100, YEL=3'b010, GRN=3'b001.
- One sub-module, phase_timer:
  - CW-bit down-counter with load/load_val/tick inputs and an `expire` output (cnt==0 && tick).
- The FSM, output decode and wr_reset register stay in traffic_phase_controller.

Test Plan:
1. Reset, tick=1 every clk, sensor=0, wr=0 → MAIN_GRN 6 clk, MAIN_YEL 2, SIDE_GRN 3, SIDE_YEL 2; period 13 clk; walk_lamp and wr_reset never high.
2. tick=1, wr=1 held from clk 3 → after MAIN_YEL, WALK lasts 3 clk with both roads R, walk_lamp=1; wr_reset=1 only in WALK's first clk; period 16.
3. sensor=1 at MAIN_GRN expiry → MAIN_EXT 3 clk before MAIN_YEL. sensor=1 at SIDE_GRN expiry → SIDE_EXT 3 clk.
4. tick every 4th clk, default parameters → MAIN_GRN spans exactly 6 tick pulses; state holds between ticks; no transition without tick.
5. rst_n→0 asynchronously mid-WALK → same instant: main_light=001, side_light=100, walk_lamp=0, wr_reset=0. After release, a full 6-tick MAIN_GRN.
6. wr rises in the same clk as MAIN_YEL expiry → WALK entered. wr rises one clk after expiry → SIDE_GRN; WALK is served on the following cycle round.
